// File: rtl/debug_access_controller.sv
// Debug access sequencer in the CPU clock domain: arbitrates the memory bus at
// instruction boundaries, runs debug reads/writes and halt/resume, pulses ACKX.
module debug_access_controller #(
   parameter int ADDR_W   = 16,
   parameter int DATA_W   = 16,
   parameter int WAIT_MAX = 15
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              REQX,
   input  logic [1:0]        CMD,
   input  logic [ADDR_W-1:0] DBG_ADDR,
   input  logic [DATA_W-1:0] DBG_WDATA,
   output logic              ACKX,
   output logic [DATA_W-1:0] DBG_RDATA,
   output logic              DBG_ERR,
   output logic              HALTED,
   output logic              HALT_REQ,
   input  logic              CPU_INSTR_END,
   output logic              CPU_GRANT,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [DATA_W-1:0] MEM_WDATA,
   output logic              MEM_RD,
   output logic              MEM_WR,
   input  logic              MEM_READY,
   input  logic [DATA_W-1:0] MEM_RDATA
);

   localparam int CNT_W = $clog2(WAIT_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WAIT_MAX);

   localparam logic [1:0] CMD_READ   = 2'b00;
   localparam logic [1:0] CMD_WRITE  = 2'b01;
   localparam logic [1:0] CMD_HALT   = 2'b10;
   localparam logic [1:0] CMD_RESUME = 2'b11;

   typedef enum logic [2:0] {IDLE, WAIT_BND, ACCESS, ACK, DONE} state_t;

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         ACKX      <= 1'b0;
         DBG_RDATA <= '0;
         DBG_ERR   <= 1'b0;
         HALTED    <= 1'b0;
         HALT_REQ  <= 1'b0;
         CPU_GRANT <= 1'b1;
         MEM_ADDR  <= '0;
         MEM_WDATA <= '0;
         MEM_RD    <= 1'b0;
         MEM_WR    <= 1'b0;
      end else begin
         ACKX <= 1'b0;
         case (state)
            IDLE: begin
               CPU_GRANT <= 1'b1;
               MEM_RD    <= 1'b0;
               MEM_WR    <= 1'b0;
               if (REQX) begin
                  case (CMD)
                     CMD_HALT: begin
                        HALTED   <= 1'b1;
                        HALT_REQ <= 1'b1;
                        ACKX     <= 1'b1;
                        state    <= ACK;
                     end
                     CMD_RESUME: begin
                        HALTED   <= 1'b0;
                        HALT_REQ <= 1'b0;
                        ACKX     <= 1'b1;
                        state    <= ACK;
                     end
                     default: begin
                        // An already-halted core is parked, so the bus can be taken at once.
                        if (HALTED) begin
                           MEM_ADDR  <= DBG_ADDR;
                           MEM_WDATA <= DBG_WDATA;
                           MEM_RD    <= (CMD == CMD_READ);
                           MEM_WR    <= (CMD == CMD_WRITE);
                           CPU_GRANT <= 1'b0;
                           wait_cnt  <= '0;
                           state     <= ACCESS;
                        end else begin
                           HALT_REQ <= 1'b1;
                           state    <= WAIT_BND;
                        end
                     end
                  endcase
               end
            end
            WAIT_BND: begin
               if (CPU_INSTR_END) begin
                  MEM_ADDR  <= DBG_ADDR;
                  MEM_WDATA <= DBG_WDATA;
                  MEM_RD    <= (CMD == CMD_READ);
                  MEM_WR    <= (CMD == CMD_WRITE);
                  CPU_GRANT <= 1'b0;
                  wait_cnt  <= '0;
                  state     <= ACCESS;
               end
            end
            ACCESS: begin
               // READY is checked first so a completion on the last wait cycle still succeeds.
               if (MEM_READY) begin
                  if (MEM_RD) DBG_RDATA <= MEM_RDATA;
                  DBG_ERR <= 1'b0;
                  MEM_RD  <= 1'b0;
                  MEM_WR  <= 1'b0;
                  ACKX    <= 1'b1;
                  state   <= ACK;
               end else if (wait_cnt == CNT_MAX) begin
                  if (MEM_RD) DBG_RDATA <= '1;
                  DBG_ERR <= 1'b1;
                  MEM_RD  <= 1'b0;
                  MEM_WR  <= 1'b0;
                  ACKX    <= 1'b1;
                  state   <= ACK;
               end else begin
                  wait_cnt <= wait_cnt + 1'b1;
               end
            end
            ACK: begin
               state <= DONE;
            end
            DONE: begin
               if (!REQX) begin
                  HALT_REQ  <= HALTED;
                  CPU_GRANT <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_access_controller.sv
// Randomised bench for debug_access_controller; expectations come from a
// per-transaction timeline computed from the command, boundary and ready delays.
module tb_debug_access_controller;

   localparam int AW = 16;
   localparam int DW = 16;
   localparam int WM = 15;

   logic          CLK = 1'b0;
   logic          RESET = 1'b1;
   logic          REQX = 1'b0;
   logic [1:0]    CMD = 2'b00;
   logic [AW-1:0] DBG_ADDR = '0;
   logic [DW-1:0] DBG_WDATA = '0;
   logic          ACKX;
   logic [DW-1:0] DBG_RDATA;
   logic          DBG_ERR;
   logic          HALTED;
   logic          HALT_REQ;
   logic          CPU_INSTR_END = 1'b0;
   logic          CPU_GRANT;
   logic [AW-1:0] MEM_ADDR;
   logic [DW-1:0] MEM_WDATA;
   logic          MEM_RD;
   logic          MEM_WR;
   logic          MEM_READY = 1'b0;
   logic [DW-1:0] MEM_RDATA = '0;

   int checks = 0;
   int errors = 0;

   logic          m_halted = 1'b0;
   logic [DW-1:0] m_rdata  = '0;
   logic          m_err    = 1'b0;

   debug_access_controller #(.ADDR_W(AW), .DATA_W(DW), .WAIT_MAX(WM)) dut (
      .CLK(CLK), .RESET(RESET), .REQX(REQX), .CMD(CMD), .DBG_ADDR(DBG_ADDR),
      .DBG_WDATA(DBG_WDATA), .ACKX(ACKX), .DBG_RDATA(DBG_RDATA), .DBG_ERR(DBG_ERR),
      .HALTED(HALTED), .HALT_REQ(HALT_REQ), .CPU_INSTR_END(CPU_INSTR_END),
      .CPU_GRANT(CPU_GRANT), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
      .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .MEM_READY(MEM_READY), .MEM_RDATA(MEM_RDATA)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   // One debug transaction. bnd: WAIT_BND cycles before CPU_INSTR_END; rd: ACCESS
   // cycles before MEM_READY (> WM means never); hold: extra cycles REQX stays high after ACKX.
   task automatic do_txn(input logic [1:0] cmd, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int bnd, input int rd,
                         input logic [DW-1:0] rdat, input int hold, input string tag);
      logic mem, rdc, timeout, halted_after, hreq_busy, err_after;
      logic [DW-1:0] rdata_after;
      int wb, acc, ack_c, idle_c, idx, bidx;
      logic e_ack, e_rd, e_wr, e_gnt, e_hreq, in_acc;
      mem     = (cmd[1] == 1'b0);
      rdc     = (cmd == 2'b00);
      timeout = mem && (rd > WM);
      wb      = (mem && !m_halted) ? bnd + 1 : 0;
      acc     = mem ? (((rd <= WM) ? rd : WM) + 1) : 0;
      ack_c   = mem ? 1 + wb + acc : 1;
      idle_c  = ack_c + 1 + ((hold > 1) ? hold : 1);
      halted_after = (cmd == 2'b10) ? 1'b1 : (cmd == 2'b11) ? 1'b0 : m_halted;
      hreq_busy    = (cmd != 2'b11);
      err_after    = mem ? timeout : m_err;
      rdata_after  = (mem && rdc) ? (timeout ? {DW{1'b1}} : rdat) : m_rdata;

      for (int c = 0; c <= idle_c; c++) begin
         if (c > 0) begin
            in_acc = mem && (c >= 1 + wb) && (c < ack_c);
            e_ack  = (c == ack_c);
            e_rd   = in_acc && rdc;
            e_wr   = in_acc && !rdc;
            e_gnt  = !(mem && (c >= 1 + wb) && (c < idle_c));
            e_hreq = (c < idle_c) ? hreq_busy : halted_after;
            checks++; if (ACKX !== e_ack) begin errors++;
               $display("FAIL %s c=%0d ACKX got %b exp %b", tag, c, ACKX, e_ack); end
            checks++; if (MEM_RD !== e_rd) begin errors++;
               $display("FAIL %s c=%0d MEM_RD got %b exp %b", tag, c, MEM_RD, e_rd); end
            checks++; if (MEM_WR !== e_wr) begin errors++;
               $display("FAIL %s c=%0d MEM_WR got %b exp %b", tag, c, MEM_WR, e_wr); end
            checks++; if (CPU_GRANT !== e_gnt) begin errors++;
               $display("FAIL %s c=%0d CPU_GRANT got %b exp %b", tag, c, CPU_GRANT, e_gnt); end
            checks++; if (HALT_REQ !== e_hreq) begin errors++;
               $display("FAIL %s c=%0d HALT_REQ got %b exp %b", tag, c, HALT_REQ, e_hreq); end
            checks++; if (HALTED !== halted_after) begin errors++;
               $display("FAIL %s c=%0d HALTED got %b exp %b", tag, c, HALTED, halted_after); end
            if (in_acc) begin
               checks++; if (MEM_ADDR !== addr || MEM_WDATA !== wdata) begin errors++;
                  $display("FAIL %s c=%0d MEM_ADDR/WDATA got %h/%h exp %h/%h",
                           tag, c, MEM_ADDR, MEM_WDATA, addr, wdata); end
            end
            checks++;
            if (c >= ack_c) begin
               if (DBG_RDATA !== rdata_after || DBG_ERR !== err_after) begin errors++;
                  $display("FAIL %s c=%0d RDATA/ERR got %h/%b exp %h/%b",
                           tag, c, DBG_RDATA, DBG_ERR, rdata_after, err_after); end
            end else begin
               if (DBG_RDATA !== m_rdata || DBG_ERR !== m_err) begin errors++;
                  $display("FAIL %s c=%0d RDATA/ERR early got %h/%b exp %h/%b",
                           tag, c, DBG_RDATA, DBG_ERR, m_rdata, m_err); end
            end
         end
         // Drive inputs for edge c+1; outside the windows where they matter they are noise.
         REQX      = (c < ack_c + hold);
         CMD       = cmd;
         DBG_ADDR  = addr;
         DBG_WDATA = wdata;
         bidx = c - 1;
         idx  = c - 1 - wb;
         if (mem && !m_halted && bidx >= 0 && bidx <= bnd) CPU_INSTR_END = (bidx == bnd);
         else CPU_INSTR_END = 1'($urandom_range(0, 1));
         if (mem && idx >= 0 && idx < acc) begin
            MEM_READY = (idx == rd);
            MEM_RDATA = rdat;
         end else begin
            MEM_READY = 1'($urandom_range(0, 1));
            MEM_RDATA = DW'($urandom);
         end
         if (c < idle_c) tick();
      end
      m_halted = halted_after;
      m_rdata  = rdata_after;
      m_err    = err_after;
   endtask

   task automatic test_reset();
      RESET = 1'b1; REQX = 1'b1; CMD = 2'b10;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ACKX !== 1'b0 || DBG_RDATA !== '0 || DBG_ERR !== 1'b0 || HALTED !== 1'b0 ||
             HALT_REQ !== 1'b0 || CPU_GRANT !== 1'b1 || MEM_ADDR !== '0 ||
             MEM_WDATA !== '0 || MEM_RD !== 1'b0 || MEM_WR !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals ack=%b rd=%h err=%b h=%b hr=%b g=%b ma=%h mw=%h r=%b w=%b exp 0/0/0/0/0/1/0/0/0/0",
                     ACKX, DBG_RDATA, DBG_ERR, HALTED, HALT_REQ, CPU_GRANT, MEM_ADDR,
                     MEM_WDATA, MEM_RD, MEM_WR);
         end
      end
      REQX = 1'b0;
      tick();
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (ACKX !== 1'b0 || CPU_GRANT !== 1'b1 || HALT_REQ !== 1'b0) begin errors++;
            $display("FAIL idle_after_reset ack=%b gnt=%b hreq=%b exp 0/1/0", ACKX, CPU_GRANT, HALT_REQ); end
      end
      m_halted = 1'b0; m_rdata = '0; m_err = 1'b0;
   endtask

   task automatic test_halt_read();
      do_txn(2'b10, 16'h0, 16'h0, 0, 0, 16'h0, 0, "halt");
      do_txn(2'b00, 16'h0040, 16'h0, 0, 0, 16'hBEEF, 0, "halted_read");
   endtask

   task automatic test_unhalted_write();
      do_txn(2'b11, 16'h0, 16'h0, 0, 0, 16'h0, 1, "resume");
      do_txn(2'b01, 16'h1234, 16'h00FF, 5, 1, 16'h0, 0, "boundary_write");
   endtask

   task automatic test_timeout();
      do_txn(2'b00, 16'h0100, 16'h0, 2, 99, 16'h1111, 0, "timeout_read");
      do_txn(2'b00, 16'h0102, 16'h0, 0, 2, 16'h5A5A, 0, "clear_err_read");
      do_txn(2'b10, 16'h0, 16'h0, 0, 0, 16'h0, 0, "halt2");
      do_txn(2'b00, 16'h0104, 16'h0, 0, WM, 16'hC0DE, 0, "ready_at_limit");
      do_txn(2'b01, 16'h0106, 16'h7777, 0, 50, 16'h0, 0, "timeout_write");
   endtask

   task automatic test_done_hold();
      do_txn(2'b00, 16'h0200, 16'h0, 0, 1, 16'h2468, 5, "done_hold");
   endtask

   task automatic test_reset_mid_access();
      do_txn(2'b11, 16'h0, 16'h0, 0, 0, 16'h0, 0, "resume2");
      REQX = 1'b1; CMD = 2'b00; DBG_ADDR = 16'h0300;
      CPU_INSTR_END = 1'b1; MEM_READY = 1'b0;
      tick(); tick();
      checks++; if (MEM_RD !== 1'b1 || CPU_GRANT !== 1'b0) begin errors++;
         $display("FAIL mid_access_pre rd=%b gnt=%b exp 1/0", MEM_RD, CPU_GRANT); end
      @(posedge CLK); #2 RESET = 1'b1; #1;
      checks++;
      if (MEM_RD !== 1'b0 || CPU_GRANT !== 1'b1 || HALTED !== 1'b0 || HALT_REQ !== 1'b0 || ACKX !== 1'b0) begin
         errors++;
         $display("FAIL async_abort rd=%b gnt=%b h=%b hr=%b ack=%b exp 0/1/0/0/0",
                  MEM_RD, CPU_GRANT, HALTED, HALT_REQ, ACKX);
      end
      @(negedge CLK); REQX = 1'b0;
      tick();
      RESET = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (ACKX !== 1'b0 || CPU_GRANT !== 1'b1) begin errors++;
            $display("FAIL post_abort ack=%b gnt=%b exp 0/1", ACKX, CPU_GRANT); end
      end
      m_halted = 1'b0; m_rdata = '0; m_err = 1'b0;
   endtask

   task automatic test_random();
      int r;
      logic [1:0] cmd;
      for (int i = 0; i < 60; i++) begin
         r = $urandom_range(0, 9);
         cmd = (r < 4) ? 2'b00 : (r < 8) ? 2'b01 : (r == 8) ? 2'b10 : 2'b11;
         do_txn(cmd, AW'($urandom), DW'($urandom), $urandom_range(0, 6),
                $urandom_range(0, 18), DW'($urandom), $urandom_range(0, 3), "random");
      end
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_halt_read();
      test_unhalted_write();
      test_timeout();
      test_done_hold();
      test_reset_mid_access();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
